multi_shift_sequencer: RTL and testbench

- Parametrised multi-cycle shifter, the successor to the single-bit right shift register in the multiply datapath.
- Loads a WIDTH-bit word and shifts it by a run-time amount, up to STEP bit positions per clock.
- Four modes: arithmetic right, logical right, logical left, rotate right.
- Tracks shifted-out bits (last bit, sticky OR) for Booth/rounding logic; start/busy/done handshake lets the multiplier controller sequence it.

---
 rtl/multi_shift_sequencer.sv | 144 ++++++++++++++
 tb/tb_multi_shift_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_shift_sequencer.sv
// Multi-cycle shifter: loads a word, then shifts it by a run-time amount,
// up to STEP bit positions per clock, tracking last shifted-out bit and a
// sticky OR of everything shifted out. start/busy/done handshake.
module multi_shift_sequencer #(
    parameter int WIDTH   = 16,
    parameter int STEP    = 1,
    parameter int SHAMT_W = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0]        shamt,
    input  logic [1:0]                mode,
    output logic signed [WIDTH-1:0]   dout,
    output logic                      busy,
    output logic                      done,
    output logic                      last_out,
    output logic                      sticky
);

    localparam logic [1:0] MODE_ASR = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SHAMT_W-1:0]   rem;
    logic [SHAMT_W-1:0]   rem_nxt;
    logic [SHAMT_W-1:0]   step_k;
    logic [1:0]           mode_q;
    logic [WIDTH-1:0]     work;
    logic                 work_last;
    logic                 work_sticky;
    logic [WIDTH:0]       one_res;

    // Single 1-bit shift; the returned MSB is the bit removed from the word.
    function automatic logic [WIDTH:0] shift_one(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       m);
        case (m)
            MODE_ASR: return {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            MODE_LSR: return {d[0], 1'b0, d[WIDTH-1:1]};
            MODE_LSL: return {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            default:  return {d[0], d[0], d[WIDTH-1:1]};
        endcase
    endfunction

    // Bits to move this edge: min(STEP, rem); the remainder counts down to zero.
    always_comb begin
        if (int'(rem) < STEP) begin
            step_k = rem;
        end else begin
            step_k = SHAMT_W'(STEP);
        end
        rem_nxt = rem - step_k;
    end

    // Apply step_k chained 1-bit shifts to the working word in one edge.
    always_comb begin
        work        = dout;
        work_last   = last_out;
        work_sticky = sticky;
        one_res     = '0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(step_k)) begin
                one_res   = shift_one(work, mode_q);
                work      = one_res[WIDTH-1:0];
                work_last = one_res[WIDTH];
                if (mode_q != MODE_ROR) begin
                    work_sticky = work_sticky | one_res[WIDTH];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; DONE lasts exactly one cycle and start is only seen in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_nxt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accepted start, shifting during SHIFT, hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dout     <= '0;
            rem      <= '0;
            mode_q   <= MODE_ASR;
            last_out <= 1'b0;
            sticky   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dout     <= din;
                        rem      <= shamt;
                        mode_q   <= mode;
                        last_out <= 1'b0;
                        sticky   <= 1'b0;
                    end
                end
                SHIFT: begin
                    dout     <= work;
                    rem      <= rem_nxt;
                    last_out <= work_last;
                    sticky   <= work_sticky;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_multi_shift_sequencer.sv
// Bench for multi_shift_sequencer: one STEP=1 and one STEP=4 instance,
// scoreboard of expected results, per-scenario tasks.
module tb_multi_shift_sequencer;

    localparam int W = 16;

    logic               clk;
    logic               reset_n;
    logic               start1;
    logic               start4;
    logic signed [W-1:0] din;
    logic [4:0]         shamt;
    logic [1:0]         mode;

    logic signed [W-1:0] dout1, dout4;
    logic busy1, done1, last1, sticky1;
    logic busy4, done4, last4, sticky4;

    int sel;
    logic signed [W-1:0] o_dout;
    logic o_busy, o_done, o_last, o_sticky;

    typedef struct packed {
        logic [W-1:0] d;
        logic         lo;
        logic         st;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int total;
    int bad;
    int ndone1;
    int exp_done1;

    multi_shift_sequencer #(.WIDTH(16), .STEP(1), .SHAMT_W(5)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .din(din), .shamt(shamt),
        .mode(mode), .dout(dout1), .busy(busy1), .done(done1),
        .last_out(last1), .sticky(sticky1)
    );

    multi_shift_sequencer #(.WIDTH(16), .STEP(4), .SHAMT_W(5)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .din(din), .shamt(shamt),
        .mode(mode), .dout(dout4), .busy(busy4), .done(done4),
        .last_out(last4), .sticky(sticky4)
    );

    assign o_dout   = (sel == 1) ? dout4   : dout1;
    assign o_busy   = (sel == 1) ? busy4   : busy1;
    assign o_done   = (sel == 1) ? done4   : done1;
    assign o_last   = (sel == 1) ? last4   : last1;
    assign o_sticky = (sel == 1) ? sticky4 : sticky1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done1) ndone1++;
    end

    function automatic logic bit_at(input logic [W-1:0] d, input int idx);
        logic [W-1:0] t;
        t = d >> idx;
        return t[0];
    endfunction

    // Closed-form reference: result bit b comes from position b+sh (or b-sh).
    function automatic void ref_shift(input logic [W-1:0] d, input int sh,
                                      input logic [1:0] m, output logic [W-1:0] r,
                                      output logic lo, output logic st);
        int n;
        n  = (sh < W) ? sh : W;
        r  = '0;
        lo = 1'b0;
        st = 1'b0;
        for (int b = 0; b < W; b++) begin
            case (m)
                2'b00:   r[b] = (b + sh < W) ? bit_at(d, b + sh) : d[W-1];
                2'b01:   r[b] = (b + sh < W) ? bit_at(d, b + sh) : 1'b0;
                2'b10:   r[b] = (b - sh >= 0) ? bit_at(d, b - sh) : 1'b0;
                default: r[b] = bit_at(d, (b + sh) % W);
            endcase
        end
        for (int b = 0; b < n; b++) begin
            if (m == 2'b00 || m == 2'b01) st = st | bit_at(d, b);
            if (m == 2'b10)               st = st | bit_at(d, W - 1 - b);
        end
        if (m == 2'b00 && sh > W) st = st | d[W-1];
        if (sh > 0) begin
            case (m)
                2'b00:   lo = (sh <= W) ? bit_at(d, sh - 1) : d[W-1];
                2'b01:   lo = (sh <= W) ? bit_at(d, sh - 1) : 1'b0;
                2'b10:   lo = (sh <= W) ? bit_at(d, W - sh) : 1'b0;
                default: lo = bit_at(d, (sh - 1) % W);
            endcase
        end
    endfunction

    // One complete operation on instance s; expectation pushed at stimulus time.
    task automatic run_op(input int s, input logic [W-1:0] d, input int sh,
                          input logic [1:0] m, input logic [W-1:0] e_d,
                          input logic e_lo, input logic e_st, input string tag);
        exp_t e;
        int   edges;
        int   stp;
        stp   = (s == 1) ? 4 : 1;
        e.d   = e_d;
        e.lo  = e_lo;
        e.st  = e_st;
        e.lat = (sh + stp - 1) / stp + 1;
        exp_q.push_back(e);
        sel = s;
        @(negedge clk);
        din   = d;
        shamt = sh[4:0];
        mode  = m;
        if (s == 1) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
        edges  = 1;
        while (!o_done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        e = exp_q.pop_front();
        total++;
        if (!o_done) begin
            bad++;
            $display("FAIL %s timeout: done not seen after %0d edges, required %0d", tag, edges, e.lat);
        end else begin
            if (s == 0) exp_done1++;
            if (o_dout !== e.d) begin
                bad++;
                $display("FAIL %s dout: got %h required %h", tag, o_dout, e.d);
            end
            total++;
            if (o_last !== e.lo) begin
                bad++;
                $display("FAIL %s last_out: got %b required %b", tag, o_last, e.lo);
            end
            total++;
            if (o_sticky !== e.st) begin
                bad++;
                $display("FAIL %s sticky: got %b required %b", tag, o_sticky, e.st);
            end
            total++;
            if (edges !== e.lat || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL %s latency/busy: got %0d/%b required %0d/1", tag, edges, o_busy, e.lat);
            end
            @(posedge clk); #1;
            total++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                bad++;
                $display("FAIL %s after-done: got done=%b busy=%b required 0/0", tag, o_done, o_busy);
            end
        end
    endtask

    task automatic run_model(input int s, input logic [W-1:0] d, input int sh,
                             input logic [1:0] m, input string tag);
        logic [W-1:0] r;
        logic lo, st;
        ref_shift(d, sh, m, r, lo, st);
        run_op(s, d, sh, m, r, lo, st, tag);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start1  = 1'b1;
        start4  = 1'b1;
        din     = 16'h1234;
        shamt   = 5'd3;
        mode    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        total++;
        if ({dout1, busy1, done1, last1, sticky1} !== 20'h0) begin
            bad++;
            $display("FAIL reset1: got dout=%h b=%b d=%b l=%b s=%b required all 0", dout1, busy1, done1, last1, sticky1);
        end
        total++;
        if ({dout4, busy4, done4, last4, sticky4} !== 20'h0) begin
            bad++;
            $display("FAIL reset4: got dout=%h b=%b d=%b l=%b s=%b required all 0", dout4, busy4, done4, last4, sticky4);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy1=%b busy4=%b required 0/0", busy1, busy4);
        end
    endtask

    task automatic test_arith();
        run_op(0, 16'h8000, 1, 2'b00, 16'hC000, 1'b0, 1'b0, "asr1");
    endtask

    task automatic test_logical();
        run_op(0, 16'h8001, 4, 2'b01, 16'h0800, 1'b0, 1'b1, "lsr4");
        run_op(0, 16'h00F0, 0, 2'b10, 16'h00F0, 1'b0, 1'b0, "lsl0");
    endtask

    task automatic test_large_amounts();
        run_op(0, 16'h0001, 17, 2'b11, 16'h8000, 1'b1, 1'b0, "ror17");
        run_op(0, 16'h8000, 20, 2'b00, 16'hFFFF, 1'b1, 1'b1, "asr20");
        run_op(0, 16'hABCD, 31, 2'b01, 16'h0000, 1'b0, 1'b1, "lsr31");
    endtask

    task automatic test_step4();
        run_op(1, 16'h1234, 6, 2'b01, 16'h0048, 1'b1, 1'b1, "s4_lsr6");
        run_op(1, 16'h8000, 20, 2'b00, 16'hFFFF, 1'b1, 1'b1, "s4_asr20");
        run_op(1, 16'h0001, 17, 2'b11, 16'h8000, 1'b1, 1'b0, "s4_ror17");
    endtask

    task automatic test_handshake();
        exp_t e;
        int   edges;
        sel     = 0;
        e.d     = 16'h0800;
        e.lo    = 1'b0;
        e.st    = 1'b1;
        e.lat   = 5;
        exp_q.push_back(e);
        @(negedge clk);
        din    = 16'h8001;
        shamt  = 5'd4;
        mode   = 2'b01;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        edges  = 1;
        // Disturb inputs and raise start while shifting.
        din    = 16'hFFFF;
        shamt  = 5'd1;
        mode   = 2'b10;
        start1 = 1'b1;
        @(posedge clk); #1;
        edges++;
        start1 = 1'b0;
        while (!done1 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        e = exp_q.pop_front();
        total++;
        if (!done1 || dout1 !== e.d || last1 !== e.lo || sticky1 !== e.st || edges !== e.lat) begin
            bad++;
            $display("FAIL hs_shift_start: got dout=%h l=%b s=%b edges=%0d required %h/%b/%b/%0d",
                     dout1, last1, sticky1, edges, e.d, e.lo, e.st, e.lat);
        end
        if (done1) exp_done1++;
        // start during the DONE cycle must be ignored too.
        din    = 16'h1234;
        shamt  = 5'd0;
        mode   = 2'b00;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        total++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || dout1 !== 16'h0800) begin
            bad++;
            $display("FAIL hs_done_start: got busy=%b done=%b dout=%h required 0/0/0800", busy1, done1, dout1);
        end
        // Reset in the middle of a long shift.
        @(negedge clk);
        din    = 16'h00FF;
        shamt  = 5'd10;
        mode   = 2'b00;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({dout1, busy1, done1, last1, sticky1} !== 20'h0) begin
            bad++;
            $display("FAIL hs_mid_reset: got dout=%h b=%b d=%b l=%b s=%b required all 0", dout1, busy1, done1, last1, sticky1);
        end
        reset_n = 1'b1;
        run_op(0, 16'h00FF, 3, 2'b00, 16'h001F, 1'b1, 1'b1, "hs_after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(0, 16'h0F0F, 2, 2'b11, 16'hC3C3, 1'b1, 1'b0, "b2b_first");
        run_op(0, 16'hFFFF, 3, 2'b10, 16'hFFF8, 1'b1, 1'b1, "b2b_second");
        run_op(0, 16'h7FFF, 0, 2'b00, 16'h7FFF, 1'b0, 1'b0, "b2b_third");
        @(negedge clk);
        total++;
        if (ndone1 !== exp_done1) begin
            bad++;
            $display("FAIL done_count: got %0d pulses required %0d", ndone1, exp_done1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            run_model(0, 16'($urandom), int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), "rand_s1");
        end
        for (int n = 0; n < 10; n++) begin
            run_model(1, 16'($urandom), int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), "rand_s4");
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        ndone1    = 0;
        exp_done1 = 0;
        sel       = 0;
        reset_n   = 1'b0;
        start1    = 1'b0;
        start4    = 1'b0;
        din       = '0;
        shamt     = '0;
        mode      = '0;
        test_reset();
        test_arith();
        test_logical();
        test_large_amounts();
        test_step4();
        test_handshake();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
